// File: rtl/lj24rx.sv
// lj24rx: left-justified serial audio receiver.
// Recovers one word per lrck channel from an asynchronous bck/lrck/data
// stream and writes it, MSB-aligned, into a downstream FIFO.
//
// Ports:
//   clk        system clock, rising edge, at least 4x the bck rate
//   reset_n    asynchronous active-low reset
//   bck_in     serial bit clock (asynchronous)
//   lrck_in    word select, 1 = left, 0 = right (asynchronous)
//   data_in    serial data, MSB first, changes on bck falling edge
//   fifo_full  downstream FIFO full
//   fifo_wrreq one-clk write strobe
//   fifo_data  received word, MSB-aligned, held between writes
//   overflow   sticky, set when a word is dropped on fifo_full
//
// Build option: define LJ24RX_CHTAG_EN to replace fifo_data[0] with the
// channel tag of the emitted word (1 = left, 0 = right).
module lj24rx (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bck_in,
  input  logic        lrck_in,
  input  logic        data_in,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [31:0] fifo_data,
  output logic        overflow
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned SW = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Synchronizer stages, bit order {bck, lrck, data}
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] hist_q;

  state_t          state_q, state_d;
  logic            have_prev_q, have_prev_d;
  logic            prev_lrck_q, prev_lrck_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            wrreq_d;
  logic [W-1:0]    data_d;
  logic            overflow_d;

  logic            bck_rise;
  logic            slot_lrck;
  logic            slot_data;
  logic            lr_change;
  logic [SW-1:0]   align_sh;
  logic [W-1:0]    aligned;
  logic [W-1:0]    emit_word;

  // Two-flop synchronizers plus history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
    end else begin
      sync1_q <= {bck_in, lrck_in, data_in};
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // lrck/data are taken from the history stage: they have been stable since
  // the previous bck falling edge, so both bits of the slot are coherent.
  assign bck_rise  = sync2_q[2] & ~hist_q[2];
  assign slot_lrck = hist_q[1];
  assign slot_data = hist_q[0];

  // The first slot after reset has no predecessor, so it cannot be a change.
  assign lr_change = have_prev_q && (slot_lrck != prev_lrck_q);

  // Left-align the received bits with zero fill; bit_cnt of 32 shifts by 0.
  assign align_sh = SW'(W) - SW'(bit_cnt_q);
  assign aligned  = shreg_q << align_sh;

`ifdef LJ24RX_CHTAG_EN
  assign emit_word = (aligned & ~W'(1)) | W'(prev_lrck_q);
`else
  assign emit_word = aligned;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state_q;
    have_prev_d = have_prev_q;
    prev_lrck_d = prev_lrck_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    wrreq_d     = 1'b0;
    data_d      = fifo_data;
    overflow_d  = overflow;

    if (bck_rise) begin
      have_prev_d = 1'b1;
      prev_lrck_d = slot_lrck;
      case (state_q)
        IDLE: begin
          if (lr_change) begin
            state_d   = RUN;
            shreg_d   = W'(slot_data);
            bit_cnt_d = CW'(1);
          end
        end
        RUN: begin
          if (lr_change) begin
            if (fifo_full) begin
              overflow_d = 1'b1;
            end else begin
              wrreq_d = 1'b1;
              data_d  = emit_word;
            end
            shreg_d   = W'(slot_data);
            bit_cnt_d = CW'(1);
          end else if (bit_cnt_q < CW'(W)) begin
            shreg_d   = {shreg_q[W-2:0], slot_data};
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_prev_q <= 1'b0;
      prev_lrck_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      fifo_wrreq  <= 1'b0;
      fifo_data   <= '0;
      overflow    <= 1'b0;
    end else begin
      have_prev_q <= have_prev_d;
      prev_lrck_q <= prev_lrck_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      fifo_wrreq  <= wrreq_d;
      fifo_data   <= data_d;
      overflow    <= overflow_d;
    end
  end

endmodule

// File: tb/tb_lj24rx.sv
// Self-checking bench for lj24rx: drives left-justified frames and compares
// written words against a per-channel reference model.
module tb_lj24rx;

  logic        clk;
  logic        reset_n;
  logic        bck_in;
  logic        lrck_in;
  logic        data_in;
  logic        fifo_full;
  logic        fifo_wrreq;
  logic [31:0] fifo_data;
  logic        overflow;

  lj24rx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bck_in     (bck_in),
    .lrck_in    (lrck_in),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_wrreq (fifo_wrreq),
    .fifo_data  (fifo_data),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Captured writes and monitor statistics
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          dbl_pulses;
  int          hold_viol;
  logic        last_wr;
  logic [31:0] last_data;
  logic        last_rst_ok;

  // Reference model: per-channel bookkeeping since the last reset
  logic        m_have_prev;
  logic        m_run;
  logic        m_lr;
  int          m_n;
  logic [63:0] m_val;
  logic        m_drop;
  logic        m_ovf;
  logic        cur_lr;

  initial begin
    last_wr     = 1'b0;
    last_data   = '0;
    last_rst_ok = 1'b0;
    dbl_pulses  = 0;
    hold_viol   = 0;
  end

  always @(negedge clk) begin
    if (fifo_wrreq === 1'b1) got_q.push_back(fifo_data);
    if (fifo_wrreq === 1'b1 && last_wr) dbl_pulses <= dbl_pulses + 1;
    if (reset_n && last_rst_ok && fifo_wrreq !== 1'b1 && fifo_data !== last_data)
      hold_viol <= hold_viol + 1;
    last_wr     <= (fifo_wrreq === 1'b1);
    last_data   <= fifo_data;
    last_rst_ok <= reset_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // First min(n,32) bits of the channel, left-aligned, zero filled
  function automatic logic [31:0] word_of(input logic lr, input int n, input logic [63:0] val);
    int          k;
    logic [63:0] top;
    logic [31:0] w;
    k   = (n < 32) ? n : 32;
    top = val >> (n - k);
    w   = 32'(top) << (32 - k);
`ifdef LJ24RX_CHTAG_EN
    w[0] = lr;
`else
    if (lr === 1'bx) w = 'x;
`endif
    return w;
  endfunction

  task automatic model_reset();
    m_have_prev = 1'b0;
    m_run       = 1'b0;
    m_drop      = 1'b0;
    m_ovf       = 1'b0;
  endtask

  task automatic bit_slot(input logic lr, input logic d);
    lrck_in = lr;
    data_in = d;
    #37 bck_in = 1'b1;
    #37 bck_in = 1'b0;
  endtask

  // Send one channel of n bits (MSB first). rst_at >= 0 pulses reset
  // before that bit index is driven.
  task automatic send_channel(input int n, input logic [63:0] val, input int rst_at);
    logic lr;
    lr = ~cur_lr;
    cur_lr = lr;
    if (m_have_prev && m_run) begin
      if (m_drop) m_ovf = 1'b1;
      else exp_q.push_back(word_of(m_lr, m_n, m_val));
      m_drop = 1'b0;
    end
    if (m_have_prev) m_run = 1'b1;
    m_have_prev = 1'b1;
    m_lr  = lr;
    m_n   = n;
    m_val = val;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        #3 reset_n = 1'b0;
        #1;
        check("rst_wrreq",    32'(fifo_wrreq), 32'd0);
        check("rst_data",     fifo_data,       32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        #20 reset_n = 1'b1;
        model_reset();
        m_have_prev = 1'b1;
      end
      bit_slot(lr, val[n-1-i]);
    end
  endtask

  task automatic compare_phase(input string tag);
    int n;
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, got_q[i], exp_q[i]);
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] v;
    tests     = 0;
    fails     = 0;
    reset_n   = 1'b0;
    bck_in    = 1'b0;
    lrck_in   = 1'b0;
    data_in   = 1'b0;
    fifo_full = 1'b0;
    cur_lr    = 1'b0;
    model_reset();

    // Reset state
    #23;
    check("reset_wrreq",    32'(fifo_wrreq), 32'd0);
    check("reset_data",     fifo_data,       32'd0);
    check("reset_overflow", 32'(overflow),   32'd0);
    #14 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // Three 32-bit stereo frames; first left word is discarded
    for (int f = 0; f < 3; f++) begin
      send_channel(32, 64'hA5A5A500, -1);
      send_channel(32, 64'h3C3C3C00, -1);
    end
    compare_phase("frames32");

    // 24-bit words, directed then random
    send_channel(24, 64'h123456, -1);
    send_channel(24, 64'hFEDCBA, -1);
    for (int f = 0; f < 4; f++) begin
      v = {32'($urandom), 32'($urandom)};
      send_channel(24, v, -1);
    end
    compare_phase("bits24");

    // 40 bits per channel, only the first 32 kept
    v = {24'd0, 32'hDEADBEEF, 8'($urandom)};
    send_channel(40, v, -1);
    v = {32'($urandom), 32'($urandom)};
    send_channel(40, v, -1);
    v = {32'($urandom), 32'($urandom)};
    send_channel(40, v, -1);
    compare_phase("bits40");

    // One emit while the FIFO is full, then normal writes
    send_channel(32, {32'd0, 32'($urandom)}, -1);
    fifo_full = 1'b1;
    m_drop    = 1'b1;
    send_channel(32, {32'd0, 32'($urandom)}, -1);
    fifo_full = 1'b0;
    send_channel(32, {32'd0, 32'($urandom)}, -1);
    send_channel(32, {32'd0, 32'($urandom)}, -1);
    compare_phase("full_drop");

    // Random channel lengths, including single-bit and over-length words
    send_channel(1, 64'h1, -1);
    send_channel(33, {32'($urandom), 32'($urandom)}, -1);
    for (int c = 0; c < 10; c++) begin
      v = {32'($urandom), 32'($urandom)};
      send_channel(int'($urandom_range(1, 40)), v, -1);
    end
    compare_phase("rand_len");

    // bck stopped: nothing is written, overflow keeps its value
    repeat (300) @(posedge clk);
    #1;
    check("bck_stop_count",    32'(got_q.size()), 32'd0);
    check("bck_stop_overflow", 32'(overflow),     32'(m_ovf));

    // Reset in the middle of a left word
    if (cur_lr) send_channel(8, {32'd0, 32'($urandom)}, -1);
    send_channel(32, {32'd0, 32'($urandom)}, 10);
    send_channel(32, {32'd0, 32'($urandom)}, -1);
    send_channel(32, {32'd0, 32'($urandom)}, -1);
    send_channel(24, {32'd0, 32'($urandom)}, -1);
    compare_phase("mid_reset");

    check("single_cycle_wrreq", 32'(dbl_pulses), 32'd0);
    check("data_hold",          32'(hold_viol),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
